// File: rtl/dfd_accumulator_control.sv
// Trace accumulator sequencing controller: write pointer, packet admission,
// in-order bank drain and flush sequencing. Carries no payload data.
module dfd_accumulator_control #(
  parameter int unsigned ACCUMULATOR_DATA_WIDTH_IN_BYTES = 64,
  parameter int unsigned BANK_DATA_WIDTH_IN_BYTES        = 16,
  parameter int unsigned MAX_PACKET_BYTES                = 16,
  localparam int unsigned NUM_BANKS = ACCUMULATOR_DATA_WIDTH_IN_BYTES / BANK_DATA_WIDTH_IN_BYTES,
  localparam int unsigned PW        = $clog2(ACCUMULATOR_DATA_WIDTH_IN_BYTES),
  localparam int unsigned BW        = $clog2(NUM_BANKS),
  localparam int unsigned LW        = $clog2(MAX_PACKET_BYTES) + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [LW-1:0]        pkt_length,
  output logic                 pkt_ready,
  input  logic                 flush_req,
  output logic                 flush_done,
  input  logic [NUM_BANKS-1:0] bank_full,
  output logic [PW-1:0]        write_byte_boundary,
  output logic [PW-1:0]        target_write_byte_boundary,
  output logic [NUM_BANKS-1:0] bank_flush,
  output logic                 out_valid,
  output logic [BW-1:0]        out_bank_idx,
  input  logic                 out_ready,
  output logic [PW:0]          occupied_bytes
);

  localparam int unsigned OW = $clog2(BANK_DATA_WIDTH_IN_BYTES);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PAD,
    ST_DRAIN,
    ST_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  wbb_q, wbb_d;
  logic [PW:0]    occ_q, occ_d;
  logic [BW-1:0]  drain_ptr_q, drain_ptr_d;
  logic [PW:0]    free_bytes;
  logic [PW:0]    add_bytes;
  logic [PW-1:0]  target;
  logic           accept;
  logic           drain;

  // State and pointer registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_RUN;
      wbb_q       <= '0;
      occ_q       <= '0;
      drain_ptr_q <= '0;
    end else begin
      state_q     <= state_d;
      wbb_q       <= wbb_d;
      occ_q       <= occ_d;
      drain_ptr_q <= drain_ptr_d;
    end
  end

  // Admission, drain handshake, flush sequencing and pointer arithmetic
  always_comb begin
    state_d     = state_q;
    drain_ptr_d = drain_ptr_q;
    add_bytes   = '0;

    free_bytes = (PW+1)'(ACCUMULATOR_DATA_WIDTH_IN_BYTES) - occ_q;
    pkt_ready  = !reset && (state_q == ST_RUN) && !flush_req &&
                 ((PW+1)'(MAX_PACKET_BYTES) <= free_bytes);
    accept     = pkt_valid && pkt_ready;
    out_valid  = !reset && bank_full[drain_ptr_q];
    drain      = out_valid && out_ready;
    bank_flush = drain ? (NUM_BANKS'(1) << drain_ptr_q) : '0;
    flush_done = !reset && (state_q == ST_DONE);

    unique case (state_q)
      ST_RUN: begin
        if (accept) begin
          add_bytes = (PW+1)'(pkt_length);
        end else if (flush_req) begin
          state_d = (wbb_q[OW-1:0] != '0) ? ST_PAD : ST_DRAIN;
        end
      end
      ST_PAD: begin
        // Pad out the partial bank so it reports full and gets drained
        add_bytes = (PW+1)'(BANK_DATA_WIDTH_IN_BYTES) - (PW+1)'(wbb_q[OW-1:0]);
        state_d   = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (occ_q == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    if (drain) drain_ptr_d = drain_ptr_q + BW'(1);

    target = wbb_q + PW'(add_bytes);
    wbb_d  = target;
    occ_d  = occ_q + add_bytes -
             (drain ? (PW+1)'(BANK_DATA_WIDTH_IN_BYTES) : (PW+1)'(0));

    target_write_byte_boundary = target;
  end

  assign write_byte_boundary = wbb_q;
  assign occupied_bytes      = occ_q;
  assign out_bank_idx        = drain_ptr_q;

  always_ff @(posedge clock) begin
    if (!reset && pkt_valid && pkt_ready) begin
      assert ((pkt_length != '0) && (pkt_length <= LW'(MAX_PACKET_BYTES)))
        else $error("illegal pkt_length %0d", pkt_length);
    end
  end

endmodule

// File: tb/tb_dfd_accumulator_control.sv
// Directed bench for dfd_accumulator_control with hand-computed expectations.
module tb_dfd_accumulator_control;

  logic       clock = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [4:0] pkt_length;
  logic       pkt_ready;
  logic       flush_req;
  logic       flush_done;
  logic [3:0] bank_full;
  logic [5:0] write_byte_boundary;
  logic [5:0] target_write_byte_boundary;
  logic [3:0] bank_flush;
  logic       out_valid;
  logic [1:0] out_bank_idx;
  logic       out_ready;
  logic [6:0] occupied_bytes;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  dfd_accumulator_control dut (
    .clock                      (clock),
    .reset                      (reset),
    .pkt_valid                  (pkt_valid),
    .pkt_length                 (pkt_length),
    .pkt_ready                  (pkt_ready),
    .flush_req                  (flush_req),
    .flush_done                 (flush_done),
    .bank_full                  (bank_full),
    .write_byte_boundary        (write_byte_boundary),
    .target_write_byte_boundary (target_write_byte_boundary),
    .bank_flush                 (bank_flush),
    .out_valid                  (out_valid),
    .out_bank_idx               (out_bank_idx),
    .out_ready                  (out_ready),
    .occupied_bytes             (occupied_bytes)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input int unsigned len, input logic fl,
                       input logic [3:0] full, input logic ordy);
    pkt_valid  = v;
    pkt_length = 5'(len);
    flush_req  = fl;
    bank_full  = full;
    out_ready  = ordy;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 4, 1'b0, 4'b0000, 1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] mask;
    int unsigned lens3 [3];
    logic [3:0]  fulls3 [3];

    // Reset values
    reset = 1'b1;
    drive(1'b0, 4, 1'b0, 4'b0000, 1'b0);
    tick();
    tick();
    check("rst_wbb", write_byte_boundary, 0);
    check("rst_occ", occupied_bytes, 0);
    check("rst_ready", pkt_ready, 0);
    check("rst_oval", out_valid, 0);
    check("rst_done", flush_done, 0);
    check("rst_flush", bank_flush, 0);
    check("rst_idx", out_bank_idx, 0);
    reset = 1'b0;

    // Four 4-byte packets back-to-back, then bank 0 drains
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 4, 1'b0, 4'b0000, 1'b1);
      check("t1_ready", pkt_ready, 1);
      check("t1_target", target_write_byte_boundary, 4 * i);
      tick();
      check("t1_wbb", write_byte_boundary, 4 * i);
      check("t1_occ", occupied_bytes, 4 * i);
    end
    drive(1'b0, 4, 1'b0, 4'b0001, 1'b1);
    check("t1_oval", out_valid, 1);
    check("t1_flush", bank_flush, 1);
    check("t1_target_idle", target_write_byte_boundary, 16);
    tick();
    check("t1_occ_drained", occupied_bytes, 0);
    check("t1_idx", out_bank_idx, 1);

    // Fill to exactly full with drain blocked, then drain 0..3
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16, 1'b0, 4'b0000, 1'b0);
      check("t2_ready", pkt_ready, 1);
      tick();
      check("t2_occ", occupied_bytes, 16 * (i + 1));
    end
    check("t2_wbb_wrap", write_byte_boundary, 0);
    drive(1'b0, 16, 1'b0, 4'b1111, 1'b0);
    check("t2_full_ready", pkt_ready, 0);
    check("t2_noflush", bank_flush, 0);
    for (int i = 0; i < 4; i++) begin
      mask = 4'b1111 << i;
      drive(1'b0, 16, 1'b0, mask, 1'b1);
      check("t2_idx", out_bank_idx, i);
      check("t2_flush", bank_flush, 1 << i);
      tick();
      check("t2_occ_drain", occupied_bytes, 48 - 16 * i);
      if (i == 0) check("t2_reopen", pkt_ready, 1);
    end
    check("t2_idx_wrap", out_bank_idx, 0);

    // Simultaneous accept and drain from occupied=40
    lens3 = '{16, 16, 8};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, lens3[i], 1'b0, 4'b0000, 1'b0);
      tick();
    end
    check("t5_occ40", occupied_bytes, 40);
    drive(1'b1, 8, 1'b0, 4'b0011, 1'b1);
    check("t5_ready", pkt_ready, 1);
    check("t5_flush", bank_flush, 1);
    check("t5_target", target_write_byte_boundary, 48);
    tick();
    check("t5_occ", occupied_bytes, 32);
    check("t5_wbb", write_byte_boundary, 48);
    check("t5_idx", out_bank_idx, 1);

    // Bring wbb to 56 while draining, then wrap with a 12-byte packet
    do_reset();
    drive(1'b1, 16, 1'b0, 4'b0000, 1'b1);
    tick();
    lens3  = '{16, 16, 8};
    fulls3 = '{4'b0001, 4'b0010, 4'b0100};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, lens3[i], 1'b0, fulls3[i], 1'b1);
      check("t3_flush", bank_flush, fulls3[i]);
      tick();
    end
    check("t3_occ8", occupied_bytes, 8);
    check("t3_wbb56", write_byte_boundary, 56);
    check("t3_idx3", out_bank_idx, 3);
    drive(1'b1, 12, 1'b0, 4'b0000, 1'b1);
    check("t3_target_wrap", target_write_byte_boundary, 4);
    tick();
    check("t3_wbb", write_byte_boundary, 4);
    check("t3_occ", occupied_bytes, 20);
    drive(1'b0, 12, 1'b0, 4'b1000, 1'b1);
    check("t3_flush3", bank_flush, 8);
    tick();
    check("t3_occ_after", occupied_bytes, 4);
    check("t3_idx0", out_bank_idx, 0);

    // Flush from wbb=20: PAD to 32, drain, done pulse
    drive(1'b1, 16, 1'b0, 4'b0000, 1'b1);
    tick();
    check("t4_wbb20", write_byte_boundary, 20);
    check("t4_occ20", occupied_bytes, 20);
    drive(1'b0, 16, 1'b1, 4'b0000, 1'b1);
    check("t4_ready_req", pkt_ready, 0);
    check("t4_target_run", target_write_byte_boundary, 20);
    tick();
    drive(1'b0, 16, 1'b0, 4'b0000, 1'b1);
    check("t4_ready_pad", pkt_ready, 0);
    check("t4_target_pad", target_write_byte_boundary, 32);
    tick();
    check("t4_wbb_pad", write_byte_boundary, 32);
    check("t4_occ_pad", occupied_bytes, 32);
    check("t4_target_drain", target_write_byte_boundary, 32);
    drive(1'b0, 16, 1'b0, 4'b0011, 1'b1);
    check("t4_flush0", bank_flush, 1);
    tick();
    check("t4_occ16", occupied_bytes, 16);
    drive(1'b0, 16, 1'b0, 4'b0010, 1'b1);
    check("t4_flush1", bank_flush, 2);
    check("t4_ready_drain", pkt_ready, 0);
    tick();
    check("t4_occ0", occupied_bytes, 0);
    check("t4_done_early", flush_done, 0);
    drive(1'b0, 16, 1'b0, 4'b0000, 1'b1);
    tick();
    check("t4_done", flush_done, 1);
    check("t4_ready_done", pkt_ready, 0);
    tick();
    check("t4_done_clear", flush_done, 0);
    check("t4_ready_run", pkt_ready, 1);

    // Reset while in DRAIN with occupied=32
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 16, 1'b0, 4'b0000, 1'b0);
      tick();
    end
    drive(1'b0, 16, 1'b1, 4'b0000, 1'b0);
    tick();
    drive(1'b0, 16, 1'b1, 4'b0000, 1'b1);
    tick();
    check("t6_occ32", occupied_bytes, 32);
    check("t6_ready_drain", pkt_ready, 0);
    reset = 1'b1;
    drive(1'b0, 16, 1'b1, 4'b0011, 1'b1);
    check("t6_oval_rst", out_valid, 0);
    check("t6_flush_rst", bank_flush, 0);
    tick();
    check("t6_wbb", write_byte_boundary, 0);
    check("t6_occ", occupied_bytes, 0);
    check("t6_idx", out_bank_idx, 0);
    check("t6_done", flush_done, 0);
    check("t6_ready_rst", pkt_ready, 0);
    reset = 1'b0;
    drive(1'b0, 16, 1'b0, 4'b0000, 1'b0);
    check("t6_ready_run", pkt_ready, 1);
    tick();
    check("t6_done_after", flush_done, 0);
    check("t6_ready_after", pkt_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
